// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler
//
// This block runs one programmable serial sequence detector over LANES input
// bit streams. A round-robin arbiter accepts at most one bit per cycle. Each
// lane keeps its own shift history and fill level, so a lane matches
// independently of how its bits are interleaved with the other lanes.
//
// A config handshake loads a new pattern and overlap mode. The block then
// clears every lane's history, one lane per cycle, and resumes arbitration.
//
// States:
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_RUN   | arbitrate lanes, shift accepted bits, accept config requests
//   S_CLEAR | wipe hist/fill of lane clr_idx_q, one lane per cycle
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   lane_valid_i   per-lane "bit offered"
//   lane_bit_i     per-lane offered bit
//   lane_ready_o   one-hot grant; bit accepted on lane_valid_i & lane_ready_o
//   cfg_valid_i    config request
//   cfg_pattern_i  new pattern (MSB is the first bit received)
//   cfg_overlap_i  1 = overlapping matches, 0 = history restarts after a match
//   cfg_ready_o    config accepted on cfg_valid_i & cfg_ready_o
//   match_valid_o  one-cycle match pulse, one clock after the accepting edge
//   match_lane_o   lane that matched; holds its last value otherwise
//   match_count_o  saturating number of matches since reset/reconfig
//   busy_o         high while the lane histories are being cleared
module seq_detect_scheduler #(
  parameter int                 LANES   = 4,
  parameter int                 PAT_LEN = 7,
  parameter logic [PAT_LEN-1:0] PATTERN = 7'b1100111,
  parameter int                 CNT_W   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [LANES-1:0]           lane_valid_i,
  input  logic [LANES-1:0]           lane_bit_i,
  output logic [LANES-1:0]           lane_ready_o,
  input  logic                       cfg_valid_i,
  input  logic [PAT_LEN-1:0]         cfg_pattern_i,
  input  logic                       cfg_overlap_i,
  output logic                       cfg_ready_o,
  output logic                       match_valid_o,
  output logic [$clog2(LANES)-1:0]   match_lane_o,
  output logic [CNT_W-1:0]           match_count_o,
  output logic                       busy_o
);

  localparam int LW = $clog2(LANES);
  localparam int FW = $clog2(PAT_LEN + 1);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic               overlap_q, overlap_d;
  logic [LW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]      clr_idx_q, clr_idx_d;
  logic               match_valid_q, match_valid_d;
  logic [LW-1:0]      match_lane_q, match_lane_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d;

  logic [PAT_LEN-1:0] hist_q [LANES];
  logic [PAT_LEN-1:0] hist_d [LANES];
  logic [FW-1:0]      fill_q [LANES];
  logic [FW-1:0]      fill_d [LANES];

  // Arbiter result
  logic          grant_any;
  logic [LW-1:0] grant_idx;

  // FSM-qualified handshakes
  logic accept;
  logic cfg_take;

  // Datapath for the granted lane
  logic [PAT_LEN-1:0] sel_hist;
  logic [FW-1:0]      sel_fill;
  logic               sel_bit;
  logic [PAT_LEN-1:0] new_hist;
  logic [FW-1:0]      new_fill;
  logic               hit;

  // --------------------------------------------------------------------------
  // Round-robin search: first valid lane at or after rr_ptr_q, with wrap.
  // The modulo is done by one conditional subtract, since both terms are
  // below LANES.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [LW:0]   sum;
    logic [LW-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < LANES; k++) begin
      sum = {1'b0, rr_ptr_q} + (LW+1)'(k);
      if (sum >= (LW+1)'(LANES)) begin
        sum = sum - (LW+1)'(LANES);
      end
      cand = sum[LW-1:0];
      if (!grant_any && lane_valid_i[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    cfg_ready_o  = 1'b0;
    busy_o       = 1'b0;
    cfg_take     = 1'b0;
    accept       = 1'b0;
    lane_ready_o = '0;
    case (state_q)
      S_RUN: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          // Config wins over lanes, so no bit is taken on the accept edge.
          cfg_take  = 1'b1;
          clr_idx_d = '0;
          state_d   = S_CLEAR;
        end else if (grant_any) begin
          lane_ready_o = LANES'(1) << grant_idx;
          accept       = 1'b1;
        end
      end
      S_CLEAR: begin
        busy_o    = 1'b1;
        clr_idx_d = clr_idx_q + LW'(1);
        if (clr_idx_q == LW'(LANES - 1)) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_RUN;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Shift/match datapath for the granted lane
  // --------------------------------------------------------------------------
  always_comb begin
    sel_hist = hist_q[grant_idx];
    sel_fill = fill_q[grant_idx];
    sel_bit  = lane_bit_i[grant_idx];
    // Shift form keeps every history bit in use; the oldest falls off the top.
    new_hist = (sel_hist << 1) | PAT_LEN'(sel_bit);
    new_fill = (sel_fill == FW'(PAT_LEN)) ? sel_fill : sel_fill + FW'(1);
    hit      = accept && (new_fill == FW'(PAT_LEN)) && (new_hist == pattern_q);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (state_q == S_CLEAR) begin
      hist_d[clr_idx_q] = '0;
      fill_d[clr_idx_q] = '0;
    end else if (accept) begin
      if (hit && !overlap_q) begin
        hist_d[grant_idx] = '0;
        fill_d[grant_idx] = '0;
      end else begin
        hist_d[grant_idx] = new_hist;
        fill_d[grant_idx] = new_fill;
      end
    end
  end

  always_comb begin
    pattern_d     = pattern_q;
    overlap_d     = overlap_q;
    rr_ptr_d      = rr_ptr_q;
    match_valid_d = hit;
    match_lane_d  = match_lane_q;
    match_count_d = match_count_q;

    if (cfg_take) begin
      pattern_d     = cfg_pattern_i;
      overlap_d     = cfg_overlap_i;
      match_count_d = '0;
    end

    if (accept) begin
      rr_ptr_d = (grant_idx == LW'(LANES - 1)) ? '0 : grant_idx + LW'(1);
    end

    if (hit) begin
      match_lane_d = grant_idx;
      if (match_count_q != {CNT_W{1'b1}}) begin
        match_count_d = match_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pattern_q     <= PATTERN;
      overlap_q     <= 1'b1;
      rr_ptr_q      <= '0;
      match_valid_q <= 1'b0;
      match_lane_q  <= '0;
      match_count_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      pattern_q     <= pattern_d;
      overlap_q     <= overlap_d;
      rr_ptr_q      <= rr_ptr_d;
      match_valid_q <= match_valid_d;
      match_lane_q  <= match_lane_d;
      match_count_q <= match_count_d;
      hist_q        <= hist_d;
      fill_q        <= fill_d;
    end
  end

  assign match_valid_o = match_valid_q;
  assign match_lane_o  = match_lane_q;
  assign match_count_o = match_count_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler. A second instance built with
// CNT_W=2 shares all inputs so counter saturation is observed on the same
// traffic. Inputs change 1 time unit after the rising edge; registered
// outputs are sampled at that point, combinational ones 1 unit later.
module tb_seq_detect_scheduler;

  localparam int LANES   = 4;
  localparam int PAT_LEN = 7;
  localparam int LW      = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [LANES-1:0]   lane_valid;
  logic [LANES-1:0]   lane_bit;
  logic [LANES-1:0]   lane_ready;
  logic               cfg_valid;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic               cfg_overlap;
  logic               cfg_ready;
  logic               match_valid;
  logic [LW-1:0]      match_lane;
  logic [7:0]         match_count;
  logic               busy;

  logic [LANES-1:0]   lane_ready2;
  logic               cfg_ready2;
  logic               match_valid2;
  logic [LW-1:0]      match_lane2;
  logic [1:0]         match_count2;
  logic               busy2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_scheduler #(
    .LANES(LANES), .PAT_LEN(PAT_LEN), .PATTERN(7'b1100111), .CNT_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .lane_valid_i(lane_valid), .lane_bit_i(lane_bit), .lane_ready_o(lane_ready),
    .cfg_valid_i(cfg_valid), .cfg_pattern_i(cfg_pattern), .cfg_overlap_i(cfg_overlap),
    .cfg_ready_o(cfg_ready),
    .match_valid_o(match_valid), .match_lane_o(match_lane),
    .match_count_o(match_count), .busy_o(busy)
  );

  seq_detect_scheduler #(
    .LANES(LANES), .PAT_LEN(PAT_LEN), .PATTERN(7'b1100111), .CNT_W(2)
  ) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .lane_valid_i(lane_valid), .lane_bit_i(lane_bit), .lane_ready_o(lane_ready2),
    .cfg_valid_i(cfg_valid), .cfg_pattern_i(cfg_pattern), .cfg_overlap_i(cfg_overlap),
    .cfg_ready_o(cfg_ready2),
    .match_valid_o(match_valid2), .match_lane_o(match_lane2),
    .match_count_o(match_count2), .busy_o(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    lane_valid = '0;
    lane_bit   = '0;
    cfg_valid  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Streams n bits (MSB first) on a single lane, checking the grant each cycle
  // and counting match pulses seen after each accepting edge.
  task automatic send_stream(input int lane, input logic [15:0] bits, input int n,
                             output int nmatch, output int last_at,
                             output int last_lane);
    nmatch    = 0;
    last_at   = -1;
    last_lane = -1;
    for (int i = 0; i < n; i++) begin
      lane_valid = LANES'(1) << lane;
      lane_bit   = {LANES{bits[n-1-i]}};
      #1;
      chk("stream_grant", 32'(lane_ready), 32'(1 << lane));
      step();
      if (match_valid) begin
        nmatch++;
        last_at   = i;
        last_lane = int'(match_lane);
      end
    end
    lane_valid = '0;
  endtask

  task automatic clear_window();
    for (int i = 0; i < LANES; i++) begin
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("clr_lane_ready", 32'(lane_ready), 32'd0);
      step();
    end
    lane_valid = '0;
    chk("clr_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int nm, at, ln, total;
    logic [6:0] pat;
    logic [3:0] exp_grant [8];
    rst         = 1'b1;
    lane_valid  = '0;
    lane_bit    = '0;
    cfg_valid   = 1'b0;
    cfg_pattern = '0;
    cfg_overlap = 1'b0;

    // Reset state and single-lane match
    do_reset();
    chk("rst_match_valid", 32'(match_valid), 32'd0);
    chk("rst_match_count", 32'(match_count), 32'd0);
    chk("rst_match_lane", 32'(match_lane), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    #1;
    chk("rst_lane_ready", 32'(lane_ready), 32'd0);
    send_stream(0, 16'b1100111, 7, nm, at, ln);
    chk("l0_nmatch", 32'(nm), 32'd1);
    chk("l0_match_at", 32'(at), 32'd6);
    chk("l0_match_lane", 32'(ln), 32'd0);
    chk("l0_count", 32'(match_count), 32'd1);
    step();
    chk("l0_pulse_one_cycle", 32'(match_valid), 32'd0);

    // Overlapping matches on lane1
    send_stream(1, 16'b110011100111, 12, nm, at, ln);
    chk("ovl_nmatch", 32'(nm), 32'd2);
    chk("ovl_last_at", 32'(at), 32'd11);
    chk("ovl_lane", 32'(ln), 32'd1);
    chk("ovl_count", 32'(match_count), 32'd3);

    // Reconfigure with overlap off while all lanes request
    lane_valid  = 4'b1111;
    cfg_valid   = 1'b1;
    cfg_pattern = 7'b1100111;
    cfg_overlap = 1'b0;
    #1;
    chk("cfg_ready_run", 32'(cfg_ready), 32'd1);
    chk("cfg_wins_lanes", 32'(lane_ready), 32'd0);
    step();
    cfg_valid = 1'b0;
    chk("cfg_edge_no_match", 32'(match_valid), 32'd0);
    chk("cfg_count_zero", 32'(match_count), 32'd0);
    clear_window();
    send_stream(1, 16'b110011100111, 12, nm, at, ln);
    chk("novl_nmatch", 32'(nm), 32'd1);
    chk("novl_at", 32'(at), 32'd6);
    chk("novl_count", 32'(match_count), 32'd1);

    // Round-robin grant order, lane2 dropping out for one cycle
    do_reset();
    exp_grant[0] = 4'b0001; exp_grant[1] = 4'b0010; exp_grant[2] = 4'b0100;
    exp_grant[3] = 4'b1000; exp_grant[4] = 4'b0001; exp_grant[5] = 4'b0010;
    exp_grant[6] = 4'b1000; exp_grant[7] = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      lane_valid = (c == 6) ? 4'b1011 : 4'b1111;
      lane_bit   = '0;
      #1;
      chk("rr_grant", 32'(lane_ready), 32'(exp_grant[c]));
      step();
    end
    lane_valid = 4'b1111;
    #1;
    chk("rr_after_drop", 32'(lane_ready), 32'd2);
    lane_valid = '0;

    // Interleaved full pattern on all four lanes
    do_reset();
    pat   = 7'b1100111;
    total = 0;
    for (int c = 0; c < 28; c++) begin
      lane_valid = 4'b1111;
      lane_bit   = {LANES{pat[6 - c/4]}};
      #1;
      chk("il_grant", 32'(lane_ready), 32'(1 << (c % 4)));
      step();
      chk("il_valid", 32'(match_valid), 32'(c >= 24));
      if (match_valid) begin
        total++;
        chk("il_lane", 32'(match_lane), 32'(c - 24));
      end
    end
    lane_valid = '0;
    chk("il_total", 32'(total), 32'd4);
    chk("il_count", 32'(match_count), 32'd4);
    chk("il_count_sat", 32'(match_count2), 32'd3);

    // Reconfigure mid-stream with lanes holding 5 bits
    do_reset();
    for (int c = 0; c < 20; c++) begin
      lane_valid = 4'b1111;
      lane_bit   = {LANES{pat[6 - c/4]}};
      step();
    end
    lane_valid  = 4'b1111;
    cfg_valid   = 1'b1;
    cfg_pattern = 7'b1010101;
    cfg_overlap = 1'b1;
    #1;
    chk("mid_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("mid_lane_ready", 32'(lane_ready), 32'd0);
    step();
    cfg_valid  = 1'b0;
    lane_valid = '0;
    clear_window();
    send_stream(3, 16'b1010101, 7, nm, at, ln);
    chk("mid_new_nmatch", 32'(nm), 32'd1);
    chk("mid_new_lane", 32'(ln), 32'd3);
    send_stream(0, 16'b11, 2, nm, at, ln);
    chk("mid_old_rest", 32'(nm), 32'd0);
    chk("mid_count", 32'(match_count), 32'd1);

    // Five matches: 8-bit counter reads 5, 2-bit counter saturates at 3
    do_reset();
    total = 0;
    for (int r = 0; r < 5; r++) begin
      send_stream(0, 16'b1100111, 7, nm, at, ln);
      total += nm;
    end
    chk("sat_total", 32'(total), 32'd5);
    chk("sat_count8", 32'(match_count), 32'd5);
    chk("sat_count2", 32'(match_count2), 32'd3);

    // Reset in the middle of a clear
    cfg_valid   = 1'b1;
    cfg_pattern = 7'b1010101;
    cfg_overlap = 1'b0;
    step();
    cfg_valid = 1'b0;
    step();
    chk("rc_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rc_busy", 32'(busy), 32'd0);
    chk("rc_count", 32'(match_count), 32'd0);
    chk("rc_cfg_ready", 32'(cfg_ready), 32'd1);
    send_stream(0, 16'b1100111, 7, nm, at, ln);
    chk("rc_default_pattern", 32'(nm), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
